// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, waits for and qualifies lock, releases
// the downstream reset, and retries a bounded number of times before giving up.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES      = 2,
    parameter int RST_PULSE_CYCLES = 16,
    parameter int STABLE_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES   = 65536,
    parameter int MAX_RETRIES      = 4,
    parameter int CNT_W            = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       pll_ready,
    output logic       sys_rst,
    output logic       lock_lost,
    output logic       fail,
    output logic [2:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE_CHK,
        S_LOCKED,
        S_FAILED
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRIES);

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [2:0]             retry_n;
    logic                   lost_n;
    logic                   attempt_fail;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    // pll_lock is asynchronous to clk; only the last synchroniser stage is used.
    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path infers a latch.
        state_n      = state;
        cnt_n        = cnt;
        retry_n      = retry_cnt;
        lost_n       = 1'b0;
        attempt_fail = 1'b0;

        unique case (state)
            S_RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (relock_req) begin
                    state_n = S_RESET_PLL;
                    cnt_n   = '0;
                end else if (lock_s) begin
                    state_n = S_STABLE_CHK;
                    cnt_n   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    attempt_fail = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_STABLE_CHK: begin
                if (relock_req) begin
                    state_n = S_RESET_PLL;
                    cnt_n   = '0;
                end else if (!lock_s) begin
                    // A drop while qualifying is a glitch, not a failed attempt.
                    state_n = S_WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_n = S_LOCKED;
                    cnt_n   = '0;
                    retry_n = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_LOCKED: begin
                if (relock_req) begin
                    state_n = S_RESET_PLL;
                    cnt_n   = '0;
                end else if (!lock_s) begin
                    lost_n       = 1'b1;
                    attempt_fail = 1'b1;
                end
            end
            S_FAILED: begin
                state_n = S_FAILED;
            end
            default: begin
                state_n = S_RESET_PLL;
                cnt_n   = '0;
            end
        endcase

        if (attempt_fail) begin
            retry_n = (retry_cnt == RETRY_MAX) ? retry_cnt : retry_cnt + 3'd1;
            state_n = (retry_n == RETRY_MAX) ? S_FAILED : S_RESET_PLL;
            cnt_n   = '0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RESET_PLL;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            pll_ready <= 1'b0;
            sys_rst   <= 1'b1;
            lock_lost <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            retry_cnt <= retry_n;
            pll_rst   <= (state_n == S_RESET_PLL) || (state_n == S_FAILED);
            pll_ready <= (state_n == S_LOCKED);
            sys_rst   <= (state_n != S_LOCKED);
            lock_lost <= lost_n;
            fail      <= fail | (state_n == S_FAILED);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: a step table for the timeout/fail path
// plus hand-written sequences for lock, glitch, lock loss, relock and mid-run reset.
module tb_pll_lock_supervisor;

    localparam int SYNC = 2;
    localparam int RSTP = 16;
    localparam int STAB = 32;
    localparam int TMO  = 200;
    localparam int MAXR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, pll_ready, sys_rst, lock_lost, fail;
    logic [2:0] retry_cnt;
    logic [7:0] obs;

    int n_vec  = 0;
    int n_miss = 0;

    pll_lock_supervisor #(
        .SYNC_STAGES(SYNC),
        .RST_PULSE_CYCLES(RSTP),
        .STABLE_CYCLES(STAB),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES(MAXR),
        .CNT_W(9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pll_lock(pll_lock),
        .relock_req(relock_req),
        .pll_rst(pll_rst),
        .pll_ready(pll_ready),
        .sys_rst(sys_rst),
        .lock_lost(lock_lost),
        .fail(fail),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {pll_rst, pll_ready, sys_rst, lock_lost, fail, retry_cnt};

    // Expected output word: {pll_rst, pll_ready, sys_rst, lock_lost, fail, retry_cnt}.
    function automatic logic [7:0] o(logic prst, logic rdy, logic srst, logic lost,
                                     logic fl, logic [2:0] rc);
        return {prst, rdy, srst, lost, fl, rc};
    endfunction

    function automatic logic [7:0] exp_rst(logic [2:0] rc);
        return o(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, rc);
    endfunction

    function automatic logic [7:0] exp_wait(logic [2:0] rc);
        return o(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rc);
    endfunction

    function automatic logic [7:0] exp_lock();
        return o(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    endfunction

    function automatic logic [7:0] exp_failed();
        return o(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'(MAXR));
    endfunction

    task automatic check(input string name, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b want %b (pll_rst,pll_ready,sys_rst,lock_lost,fail,retry[2:0])",
                     name, obs, exp);
        end
    endtask

    // Outputs are registered, so sampling 1 time unit after the edge is safe.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        pll_lock   = 1'b0;
        relock_req = 1'b0;
        tick(2);
        check("reset_state", exp_rst(3'd0));
        rst = 1'b0;
    endtask

    typedef struct {
        int         n;
        logic       rst;
        logic       lock;
        logic       relock;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Lock never arrives: four timed-out attempts, then FAILED, then rst recovers.
        tbl[0]  = '{15,  1'b0, 1'b0, 1'b0, exp_rst(3'd0)};
        tbl[1]  = '{1,   1'b0, 1'b0, 1'b0, exp_wait(3'd0)};
        tbl[2]  = '{199, 1'b0, 1'b0, 1'b0, exp_wait(3'd0)};
        tbl[3]  = '{1,   1'b0, 1'b0, 1'b0, exp_rst(3'd1)};
        tbl[4]  = '{15,  1'b0, 1'b0, 1'b0, exp_rst(3'd1)};
        tbl[5]  = '{1,   1'b0, 1'b0, 1'b0, exp_wait(3'd1)};
        tbl[6]  = '{200, 1'b0, 1'b0, 1'b0, exp_rst(3'd2)};
        tbl[7]  = '{16,  1'b0, 1'b0, 1'b0, exp_wait(3'd2)};
        tbl[8]  = '{200, 1'b0, 1'b0, 1'b0, exp_rst(3'd3)};
        tbl[9]  = '{16,  1'b0, 1'b0, 1'b0, exp_wait(3'd3)};
        tbl[10] = '{199, 1'b0, 1'b0, 1'b0, exp_wait(3'd3)};
        tbl[11] = '{1,   1'b0, 1'b0, 1'b0, exp_failed()};
        tbl[12] = '{100, 1'b0, 1'b1, 1'b1, exp_failed()};
        tbl[13] = '{1,   1'b1, 1'b0, 1'b0, exp_rst(3'd0)};
        tbl[14] = '{15,  1'b0, 1'b0, 1'b0, exp_rst(3'd0)};
        tbl[15] = '{1,   1'b0, 1'b0, 1'b0, exp_wait(3'd0)};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            rst        = tbl[i].rst;
            pll_lock   = tbl[i].lock;
            relock_req = tbl[i].relock;
            tick(tbl[i].n);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end
        relock_req = 1'b0;

        // Nominal lock: lock raised 50 cycles into WAIT_LOCK; after SYNC cycles it is
        // seen, one cycle to enter STABLE_CHK, then STAB qualifying cycles.
        do_reset();
        tick(RSTP);
        check("nom_wait", exp_wait(3'd0));
        tick(50);
        pll_lock = 1'b1;
        tick(SYNC + STAB);
        check("nom_not_yet", exp_wait(3'd0));
        tick(1);
        check("nom_locked", exp_lock());

        // Lock drop in LOCKED: pulse, retry, fresh 16-cycle pll_rst, relock clears retry.
        pll_lock = 1'b0;
        tick(SYNC);
        check("drop_pre", exp_lock());
        tick(1);
        check("drop_pulse", o(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1));
        tick(1);
        check("drop_pulse_end", exp_rst(3'd1));
        tick(RSTP - 2);
        check("drop_rst_hi", exp_rst(3'd1));
        tick(1);
        check("drop_rst_lo", exp_wait(3'd1));
        pll_lock = 1'b1;
        tick(SYNC + STAB);
        check("relock_pending", exp_wait(3'd1));
        tick(1);
        check("relock_clears_retry", exp_lock());

        // relock_req on the same cycle the synchronised lock drops: relock wins.
        pll_lock = 1'b0;
        tick(SYNC);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check("relock_vs_drop", exp_rst(3'd0));
        tick(1);
        check("relock_no_late_pulse", exp_rst(3'd0));
        tick(RSTP - 1);
        check("relock_wait", exp_wait(3'd0));
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check("relock_in_wait", exp_rst(3'd0));

        // Glitchy lock: 10-cycle high pulse aborts qualification without a retry.
        do_reset();
        tick(RSTP);
        pll_lock = 1'b1;
        tick(10);
        pll_lock = 1'b0;
        tick(3);
        check("glitch_back_to_wait", exp_wait(3'd0));
        pll_lock = 1'b1;
        tick(SYNC + STAB);
        check("glitch_relock_pending", exp_wait(3'd0));
        tick(1);
        check("glitch_then_lock", exp_lock());

        // rst during STABLE_CHK with a nonzero retry count.
        do_reset();
        tick(RSTP + TMO);
        check("e_timeout", exp_rst(3'd1));
        tick(RSTP);
        pll_lock = 1'b1;
        tick(5);
        check("e_stable", exp_wait(3'd1));
        rst = 1'b1;
        tick(1);
        check("e_rst_mid", exp_rst(3'd0));
        rst      = 1'b0;
        pll_lock = 1'b0;
        tick(RSTP - 1);
        check("e_restart_hi", exp_rst(3'd0));
        tick(1);
        check("e_restart_lo", exp_wait(3'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_vec);
        $fatal(1);
    end

endmodule
